// File: rtl/hazard_scoreboard_if.sv
// Bundle between the D/E pipeline control and hazard_scoreboard: D-stage operand
// and destination fields, branch flush, W-stage result, and the stall/flush/forward controls.
interface hazard_scoreboard_if #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 16
);
    logic              d_valid;
    logic [REG_AW-1:0] d_rs1;
    logic [REG_AW-1:0] d_rs2;
    logic [REG_AW-1:0] d_rd;
    logic              d_regwrite;
    logic              d_is_load;
    logic              flush;
    logic [WIDTH-1:0]  w_result;

    logic              stall_f;
    logic              stall_d;
    logic              flush_d;
    logic              bubble_e;
    logic [SEL_W-1:0]  fwd_a;
    logic [SEL_W-1:0]  fwd_b;
    logic [WIDTH-1:0]  retired_data;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output d_valid, d_rs1, d_rs2, d_rd, d_regwrite, d_is_load, flush, w_result,
        input  stall_f, stall_d, flush_d, bubble_e, fwd_a, fwd_b, retired_data, stall_cycles
    );

    modport slave (
        input  d_valid, d_rs1, d_rs2, d_rd, d_regwrite, d_is_load, flush, w_result,
        output stall_f, stall_d, flush_d, bubble_e, fwd_a, fwd_b, retired_data, stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller tracking in-flight destinations from E (entry 1) to W (entry DEPTH).
// Optional macro HAZARD_WB_BYPASS_EN adds a retired slot forwardable as select DEPTH+1.
module hazard_scoreboard #(
    parameter int WIDTH      = 32,
    parameter int REG_AW     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_AVAIL = 3,
    parameter int CNT_W      = 16
) (
    input logic           clk,
    input logic           rst,
    hazard_scoreboard_if.slave sb
);
    localparam int SEL_W = $clog2(DEPTH + 2);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              is_load;
    } entry_t;

    entry_t            ent_q [1:DEPTH];
    entry_t            ent_d [1:DEPTH];
    logic [REG_AW-1:0] e_rs1_q, e_rs1_d;
    logic [REG_AW-1:0] e_rs2_q, e_rs2_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
`ifdef HAZARD_WB_BYPASS_EN
    entry_t            ret_q, ret_d;
    logic [WIDTH-1:0]  ret_data_q, ret_data_d;
`else
    logic              unused_w_result;
    assign unused_w_result = ^sb.w_result;
`endif

    logic              load_use;
    logic              stall;
    logic              bubble;
    logic [SEL_W:0]    pick_a;
    logic [SEL_W:0]    pick_b;

    function automatic logic producer(input entry_t e, input logic [REG_AW-1:0] s);
        return e.valid && e.regwrite && (e.rd == s) && (s != '0);
    endfunction

    // Returns {unreachable_load, select}; walks oldest to youngest so the youngest match wins.
    function automatic logic [SEL_W:0] fwd_pick(input logic [REG_AW-1:0] s);
        logic [SEL_W-1:0] sel;
        logic             bad;
        sel = '0;
        bad = 1'b0;
`ifdef HAZARD_WB_BYPASS_EN
        if (producer(ret_q, s)) begin
            bad = ret_q.is_load && (DEPTH + 1 < LOAD_AVAIL);
            sel = bad ? '0 : SEL_W'(DEPTH + 1);
        end
`endif
        for (int k = DEPTH; k >= 2; k--) begin
            if (producer(ent_q[k], s)) begin
                bad = ent_q[k].is_load && (k < LOAD_AVAIL);
                sel = bad ? '0 : SEL_W'(k);
            end
        end
        return {bad, sel};
    endfunction

    always_comb begin
        load_use = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (ent_q[k].is_load && (k + 1 < LOAD_AVAIL) &&
                (producer(ent_q[k], sb.d_rs1) || producer(ent_q[k], sb.d_rs2)))
                load_use = 1'b1;
        end
        load_use = load_use && sb.d_valid;
        stall    = load_use && !sb.flush;
        bubble   = load_use || sb.flush;
        pick_a   = fwd_pick(e_rs1_q);
        pick_b   = fwd_pick(e_rs2_q);
    end

    // Sources of an invalid E slot are stored as x0 so they can never match.
    always_comb begin
        ent_d[1] = '0;
        e_rs1_d  = '0;
        e_rs2_d  = '0;
        if (sb.d_valid && !bubble) begin
            ent_d[1].valid    = 1'b1;
            ent_d[1].rd       = sb.d_rd;
            ent_d[1].regwrite = sb.d_regwrite;
            ent_d[1].is_load  = sb.d_is_load;
            e_rs1_d           = sb.d_rs1;
            e_rs2_d           = sb.d_rs2;
        end
        for (int k = 2; k <= DEPTH; k++) begin
            ent_d[k] = ent_q[k-1];
        end
        stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
`ifdef HAZARD_WB_BYPASS_EN
        ret_d      = ent_q[DEPTH];
        ret_data_d = sb.w_result;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 1; k <= DEPTH; k++) begin
                ent_q[k] <= '0;
            end
            e_rs1_q     <= '0;
            e_rs2_q     <= '0;
            stall_cnt_q <= '0;
`ifdef HAZARD_WB_BYPASS_EN
            ret_q       <= '0;
            ret_data_q  <= '0;
`endif
        end else begin
            for (int k = 1; k <= DEPTH; k++) begin
                ent_q[k] <= ent_d[k];
            end
            e_rs1_q     <= e_rs1_d;
            e_rs2_q     <= e_rs2_d;
            stall_cnt_q <= stall_cnt_d;
`ifdef HAZARD_WB_BYPASS_EN
            ret_q       <= ret_d;
            ret_data_q  <= ret_data_d;
`endif
        end
    end

    // A load seen before LOAD_AVAIL means the stall logic let a dependent slip through.
    always @(posedge clk) begin
        if (rst) begin
            assert (!(pick_a[SEL_W] || pick_b[SEL_W]));
        end
    end

    assign sb.stall_f      = rst && stall;
    assign sb.stall_d      = rst && stall;
    assign sb.flush_d      = rst && sb.flush;
    assign sb.bubble_e     = rst && bubble;
    assign sb.fwd_a        = rst ? pick_a[SEL_W-1:0] : '0;
    assign sb.fwd_b        = rst ? pick_b[SEL_W-1:0] : '0;
    assign sb.stall_cycles = rst ? stall_cnt_q : '0;
`ifdef HAZARD_WB_BYPASS_EN
    assign sb.retired_data = rst ? ret_data_q : '0;
`else
    assign sb.retired_data = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (DEPTH=3, LOAD_AVAIL=3, 2-bit stall counter to reach saturation).
// Expected retired-slot results follow HAZARD_WB_BYPASS_EN.
module tb_hazard_scoreboard;
    localparam int TB_CNT_W = 2;

`ifdef HAZARD_WB_BYPASS_EN
    localparam logic [31:0] EXP_RET_SEL  = 32'd4;
    localparam logic [31:0] EXP_RET_DATA = 32'hDEADBEEF;
`else
    localparam logic [31:0] EXP_RET_SEL  = 32'd0;
    localparam logic [31:0] EXP_RET_DATA = 32'd0;
`endif

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    hazard_scoreboard_if #(.WIDTH(32), .REG_AW(5), .SEL_W(3), .CNT_W(TB_CNT_W)) bus ();

    hazard_scoreboard #(
        .WIDTH(32), .REG_AW(5), .DEPTH(3), .LOAD_AVAIL(3), .CNT_W(TB_CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sb (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, required normal completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, required %0h", tag, got, exp);
        end
    endtask

    // Advances one cycle, then presents the next D-stage instruction; outputs settle by the negedge.
    task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic rw, input logic ld,
                                 input logic fl, input logic [31:0] wres);
        @(posedge clk);
        #1;
        bus.d_valid    = v;
        bus.d_rs1      = rs1;
        bus.d_rs2      = rs2;
        bus.d_rd       = rd;
        bus.d_regwrite = rw;
        bus.d_is_load  = ld;
        bus.flush      = fl;
        bus.w_result   = wres;
    endtask

    task automatic nop();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst            = 1'b0;
        bus.d_valid    = 1'b0;
        bus.d_rs1      = '0;
        bus.d_rs2      = '0;
        bus.d_rd       = '0;
        bus.d_regwrite = 1'b0;
        bus.d_is_load  = 1'b0;
        bus.flush      = 1'b1;
        bus.w_result   = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_flush_d", 32'(bus.flush_d), 32'd0);
        checkOutput("rst_bubble_e", 32'(bus.bubble_e), 32'd0);
        checkOutput("rst_stall_f", 32'(bus.stall_f), 32'd0);
        checkOutput("rst_cycles", 32'(bus.stall_cycles), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        bus.flush = 1'b0;

        nop();
        @(negedge clk);
        checkOutput("post_rst_fwd_a", 32'(bus.fwd_a), 32'd0);
        checkOutput("post_rst_retired", bus.retired_data, 32'd0);

        // ALU producer followed immediately by its consumer
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 5'd5, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        checkOutput("alu_raw_nostall", 32'(bus.stall_d), 32'd0);
        nop();
        @(negedge clk);
        checkOutput("alu_fwd_a", 32'(bus.fwd_a), 32'd2);
        checkOutput("alu_fwd_b", 32'(bus.fwd_b), 32'd0);

        // Load-use: one stall cycle, then forward from W
        applyStimulus(1'b1, 5'd1, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, 5'd0, 5'd6, 5'd10, 1'b1, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        checkOutput("lu_stall_f", 32'(bus.stall_f), 32'd1);
        checkOutput("lu_stall_d", 32'(bus.stall_d), 32'd1);
        checkOutput("lu_bubble_e", 32'(bus.bubble_e), 32'd1);
        checkOutput("lu_flush_d", 32'(bus.flush_d), 32'd0);
        applyStimulus(1'b1, 5'd0, 5'd6, 5'd10, 1'b1, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        checkOutput("lu_stall_end", 32'(bus.stall_d), 32'd0);
        checkOutput("lu_cycles", 32'(bus.stall_cycles), 32'd1);
        nop();
        @(negedge clk);
        checkOutput("lu_fwd_b", 32'(bus.fwd_b), 32'd3);
        checkOutput("lu_fwd_a", 32'(bus.fwd_a), 32'd0);

        // Producer reaches the retired slot while the consumer sits in E
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 5'd7, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("ret_nostall", 32'(bus.stall_d), 32'd0);
        nop();
        @(negedge clk);
        checkOutput("ret_fwd_a", 32'(bus.fwd_a), EXP_RET_SEL);
        checkOutput("ret_data", bus.retired_data, EXP_RET_DATA);

        // Two writers of x8: the younger one must win
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 5'd8, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0, 32'd0);
        nop();
        @(negedge clk);
        checkOutput("youngest_fwd_a", 32'(bus.fwd_a), 32'd2);

        // x0 never produces: neither a load-use stall nor a forward
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        checkOutput("x0_nostall", 32'(bus.stall_d), 32'd0);
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd15, 1'b1, 1'b0, 1'b0, 32'd0);
        nop();
        @(negedge clk);
        checkOutput("x0_fwd_a", 32'(bus.fwd_a), 32'd0);
        checkOutput("x0_fwd_b", 32'(bus.fwd_b), 32'd0);

        // Flush beats a simultaneous load-use stall
        applyStimulus(1'b1, 5'd2, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, 5'd6, 5'd0, 5'd16, 1'b1, 1'b0, 1'b1, 32'd0);
        @(negedge clk);
        checkOutput("fl_flush_d", 32'(bus.flush_d), 32'd1);
        checkOutput("fl_bubble_e", 32'(bus.bubble_e), 32'd1);
        checkOutput("fl_stall_f", 32'(bus.stall_f), 32'd0);
        checkOutput("fl_stall_d", 32'(bus.stall_d), 32'd0);
        nop();
        @(negedge clk);
        checkOutput("fl_cycles", 32'(bus.stall_cycles), 32'd1);
        checkOutput("fl_flush_clr", 32'(bus.flush_d), 32'd0);

        // Reset lands on a stall cycle
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd20, 1'b1, 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, 5'd0, 5'd20, 5'd21, 1'b1, 1'b0, 1'b0, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rs_stall_f", 32'(bus.stall_f), 32'd0);
        checkOutput("rs_stall_d", 32'(bus.stall_d), 32'd0);
        checkOutput("rs_bubble_e", 32'(bus.bubble_e), 32'd0);
        checkOutput("rs_cycles", 32'(bus.stall_cycles), 32'd0);
        applyStimulus(1'b1, 5'd0, 5'd20, 5'd21, 1'b1, 1'b0, 1'b0, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rs_after_stall", 32'(bus.stall_d), 32'd0);
        checkOutput("rs_after_fwd_a", 32'(bus.fwd_a), 32'd0);
        checkOutput("rs_after_fwd_b", 32'(bus.fwd_b), 32'd0);
        checkOutput("rs_after_cycles", 32'(bus.stall_cycles), 32'd0);

        // Four load-use stalls against a 2-bit counter: holds at 3
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'd0, 5'd0, 5'd21, 1'b1, 1'b1, 1'b0, 32'd0);
            applyStimulus(1'b1, 5'd21, 5'd0, 5'd22, 1'b1, 1'b0, 1'b0, 32'd0);
            @(negedge clk);
            checkOutput("sat_stall", 32'(bus.stall_d), 32'd1);
            applyStimulus(1'b1, 5'd21, 5'd0, 5'd22, 1'b1, 1'b0, 1'b0, 32'd0);
        end
        nop();
        @(negedge clk);
        checkOutput("sat_cycles", 32'(bus.stall_cycles), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
